muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with HI/LO result registers, sitting beside the ALU in the

---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit with HI/LO result registers. It sits beside
// the ALU in the execute stage. Radix-2 shift-add multiply and restoring divide
// produce one bit per cycle. The datapath stalls while busy is high.
//
// Optional feature macro: MUL_DIV_DIVIDE_EN
//   defined   : DIV/DIVU are iterative like MULT/MULTU.
//   undefined : the divider datapath is absent. DIV/DIVU behave like a one-cycle
//               no-op that still pulses done. hi/lo are left unchanged.
//
// Parameters
//   WIDTH  operand/result width (even, >= 4)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   start  in   issue request; ignored unless idle
//   op     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//               11x no-op
//   a      in   rs operand: multiplicand / dividend / MTHI-MTLO source
//   b      in   rt operand: multiplier / divisor
//   busy   out  high while a multiply/divide is in flight
//   done   out  one-cycle pulse, hi/lo were just updated
//   hi     out  product upper half / remainder
//   lo     out  product lower half / quotient
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // Working registers. hi/lo stay architecturally stable until FIX.
  // Multiply: work_hi = partial-product accumulator, work_lo = multiplier.
  // Divide:   work_hi = partial remainder, work_lo = dividend/quotient.
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] b_reg;      // multiplicand or divisor magnitude
  logic             neg_res;    // negate product / quotient in FIX
`ifdef MUL_DIV_DIVIDE_EN
  logic             neg_rem;    // remainder follows dividend sign
  logic             div0;       // divisor was zero
  logic             is_div;
`endif

  // Operand magnitudes. MULT and DIV have op[0]==0 and are the signed forms.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  // The most-negative value maps to itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One iteration of the selected algorithm, plus the FIX-stage results.
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH-1:0]   work_hi_n;
  logic [WIDTH-1:0]   work_lo_n;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MUL_DIV_DIVIDE_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path can leave one unassigned and infer a latch.
    mult_sum  = {1'b0, work_hi} + {1'b0, (work_lo[0] ? b_reg : '0)};
    work_hi_n = mult_sum[WIDTH:1];
    work_lo_n = {mult_sum[0], work_lo[WIDTH-1:1]};
`ifdef MUL_DIV_DIVIDE_EN
    // Restoring step. The partial remainder is always below the divisor, so
    // bit WIDTH of the difference is set exactly when the subtraction borrows.
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        work_hi_n = div_diff[WIDTH-1:0];
        work_lo_n = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        work_hi_n = div_shift[WIDTH-1:0];
        work_lo_n = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
    // A zero divisor leaves the dividend magnitude in the remainder. Restoring
    // the dividend sign gives back the original a, so only lo needs an override.
    quo_fix = div0 ? '1 : (neg_res ? -work_lo : work_lo);
    rem_fix = neg_rem ? -work_hi : work_hi;
`endif
    prod     = {work_hi, work_lo};
    prod_fix = neg_res ? -prod : prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values no matter what order they are written in.
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= '0;
      b_reg   <= '0;
      neg_res <= 1'b0;
`ifdef MUL_DIV_DIVIDE_EN
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      is_div  <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                work_hi <= '0;
                work_lo <= b_mag;
                b_reg   <= a_mag;
                neg_res <= a_neg ^ b_neg;
`ifdef MUL_DIV_DIVIDE_EN
                is_div  <= 1'b0;
`endif
                cnt     <= CW'(WIDTH);
                busy    <= 1'b1;
                state   <= RUN;
              end
`ifdef MUL_DIV_DIVIDE_EN
              OP_DIV, OP_DIVU: begin
                work_hi <= '0;
                work_lo <= a_mag;
                b_reg   <= b_mag;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                div0    <= (b == '0);
                is_div  <= 1'b1;
                cnt     <= CW'(WIDTH);
                busy    <= 1'b1;
                state   <= RUN;
              end
`else
              OP_DIV, OP_DIVU: done <= 1'b1;
`endif
              OP_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;  // 11x: no-op
            endcase
          end
        end
        RUN: begin
          work_hi <= work_hi_n;
          work_lo <= work_lo_n;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
`ifdef MUL_DIV_DIVIDE_EN
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
`else
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed self-checking bench for muldiv_unit (WIDTH=32). Expectations for
// DIV/DIVU follow MUL_DIV_DIVIDE_EN, so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Issues one op from a negedge. lat is the index of the edge (E0 = accept)
  // after which done is first seen, or -1 if it never arrives. busy_ok checks
  // that busy matched exp_busy while waiting and was low once done was seen.
  // hold_ok checks that hi/lo held their old values until done. pulse_ok
  // checks that done and busy are low one edge after done was seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic exp_busy, output int lat, output logic busy_ok,
                        output logic hold_ok, output logic pulse_ok);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1; pulse_ok = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (done === 1'b1) begin
        lat = n;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== exp_busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
    end
    @(posedge clk); #1;
    if (done !== 1'b0 || busy !== 1'b0) pulse_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; op = 3'b110; a = '0; b = '0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int lat; logic bo, ho, po;
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, lat, bo, ho, po);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d required 33", lat); end
    n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL multu_busy: busy not high E0..E32 or not low at done"); end
    n_checks++; if (po !== 1'b1) begin n_fail++; $display("FAIL multu_done_pulse: done/busy not low after pulse"); end
    n_checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu_result: hi=%h lo=%h required 00000001 fffffffe", hi, lo);
    end
    // 2^31 * 2^31 = 2^62
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, lat, bo, ho, po);
    n_checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
      n_fail++; $display("FAIL multu_big: hi=%h lo=%h required 40000000 00000000", hi, lo);
    end
  endtask

  task automatic test_mult();
    int lat; logic bo, ho, po;
    do_reset();
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, lat, bo, ho, po);
    n_checks++; if (ho !== 1'b1) begin n_fail++; $display("FAIL mult_hold: hi/lo changed before E33"); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d required 33", lat); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mult_neg: hi=%h lo=%h required ffffffff ffffffeb", hi, lo);
    end
    // -5 * -6 = 30
    run_op(3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1, lat, bo, ho, po);
    n_checks++;
    if (hi !== 32'h0000_0000 || lo !== 32'h0000_001E) begin
      n_fail++; $display("FAIL mult_negneg: hi=%h lo=%h required 00000000 0000001e", hi, lo);
    end
  endtask

  task automatic test_divide();
    int lat; logic bo, ho, po;
    logic [31:0] hi_prev, lo_prev;
`ifdef MUL_DIV_DIVIDE_EN
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, lat, bo, ho, po);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d required 33", lat); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_neg: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
    end
    run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 1'b1, lat, bo, ho, po);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_zero_latency: got %0d required 33", lat); end
    n_checks++;
    if (hi !== 32'h0000_0007 || lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL divu_zero: hi=%h lo=%h required 00000007 ffffffff", hi, lo);
    end
    // 100 / 7 = 14 remainder 2
    run_op(3'b011, 32'd100, 32'd7, 1'b1, lat, bo, ho, po);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++; $display("FAIL divu_plain: hi=%h lo=%h required 00000002 0000000e", hi, lo);
    end
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bo, ho, po);
    n_checks++; if (po !== 1'b1) begin n_fail++; $display("FAIL div_ovf_pulse: done not a single pulse"); end
    n_checks++;
    if (hi !== 32'h0000_0000 || lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_ovf: hi=%h lo=%h required 00000000 80000000", hi, lo);
    end
`else
    hi_prev = hi; lo_prev = lo;
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, lat, bo, ho, po);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL div_off_latency: got %0d required 0", lat); end
    n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL div_off_busy: busy rose for disabled DIV"); end
    n_checks++;
    if (hi !== hi_prev || lo !== lo_prev) begin
      n_fail++; $display("FAIL div_off_hold: hi=%h lo=%h required %h %h", hi, lo, hi_prev, lo_prev);
    end
    run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 1'b0, lat, bo, ho, po);
    n_checks++;
    if (lat !== 0 || hi !== hi_prev || lo !== lo_prev) begin
      n_fail++; $display("FAIL divu_off: lat=%0d hi=%h lo=%h required 0 %h %h", lat, hi, lo, hi_prev, lo_prev);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    int lat; logic bo, ho, po;
    int edges;
    logic [31:0] hi0;
    hi0 = hi;
    edges = -1;
    start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0000_0002;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h0000_1234;
    @(posedge clk); #1;  // E5
    start = 1'b0;
    n_checks++;
    if (hi !== hi0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_mthi_ignored: hi=%h busy=%b required %h 1", hi, busy, hi0);
    end
    for (int n = 6; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin edges = n; break; end
    end
    n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL busy_multu_latency: got %0d required 33", edges); end
    n_checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL busy_multu_result: hi=%h lo=%h required 00000001 fffffffe", hi, lo);
    end
    @(negedge clk);
    run_op(3'b100, 32'h0000_1234, 32'h0, 1'b0, lat, bo, ho, po);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL mthi_latency: got %0d required 0", lat); end
    n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL mthi_busy: busy rose for MTHI"); end
    n_checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL mthi_result: hi=%h lo=%h required 00001234 fffffffe", hi, lo);
    end
  endtask

  task automatic test_noop();
    logic [31:0] hi0, lo0;
    logic seen;
    hi0 = hi; lo0 = lo; seen = 1'b0;
    start = 1'b1; op = 3'b111; a = 32'hDEAD_BEEF; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 1'b0 || hi !== hi0 || lo !== lo0) begin
      n_fail++; $display("FAIL noop: activity=%b hi=%h lo=%h required 0 %h %h", seen, hi, lo, hi0, lo0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0000_0002;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++; $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = 3'b101; a = 32'h0000_0005;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (lo !== 32'h0000_0005 || hi !== 32'h0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mtlo_after_reset: lo=%h hi=%h done=%b busy=%b required 00000005 00000000 1 0",
                         lo, hi, done, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_divide();
    test_start_while_busy();
    test_noop();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
